// File: rtl/tron_player_engine.sv
// tron_player_engine: N-player light-cycle engine. Holds a position,
// direction and live flag per player, advances all of them on a step
// tick, resolves edge and head-on deaths, then plots each head into the
// VGA adapter one player per cycle.

// Per-player next-state logic: turn decision, move and edge handling.
module tron_lane #(
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119,
  parameter int WRAP  = 0
) (
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [1:0] dir,
  input  logic [3:0] req,
  output logic [7:0] nx,
  output logic [6:0] ny,
  output logic [1:0] ndir,
  output logic       edge_die
);
  localparam logic [7:0] XM = 8'(X_MAX);
  localparam logic [6:0] YM = 7'(Y_MAX);

  logic [1:0] req_dir;

  // Turn first (one-hot, non-reversing requests only), then move in the new direction.
  always_comb begin
    req_dir  = dir;
    case (req)
      4'b0001: req_dir = 2'd1;  // right
      4'b0010: req_dir = 2'd0;  // down
      4'b0100: req_dir = 2'd2;  // up
      4'b1000: req_dir = 2'd3;  // left
      default: req_dir = dir;
    endcase
    ndir     = ($onehot(req) && (req_dir != (dir ^ 2'd2))) ? req_dir : dir;
    nx       = x;
    ny       = y;
    edge_die = 1'b0;
    case (ndir)
      2'd0: if (y == YM) begin
              if (WRAP != 0) ny = 7'd0; else edge_die = 1'b1;
            end else ny = y + 7'd1;
      2'd1: if (x == XM) begin
              if (WRAP != 0) nx = 8'd0; else edge_die = 1'b1;
            end else nx = x + 8'd1;
      2'd2: if (y == 7'd0) begin
              if (WRAP != 0) ny = YM; else edge_die = 1'b1;
            end else ny = y - 7'd1;
      default: if (x == 8'd0) begin
              if (WRAP != 0) nx = XM; else edge_die = 1'b1;
            end else nx = x - 8'd1;
    endcase
  end
endmodule

module tron_player_engine #(
  parameter int          N_PLAYERS = 2,
  parameter int          X_MAX     = 159,
  parameter int          Y_MAX     = 119,
  parameter int          WRAP      = 0,
  parameter logic [11:0] COLOURS   = 12'b000_010_100_001
) (
  input  logic                   CLOCK_50,
  input  logic                   resetn,
  input  logic                   go,
  input  logic                   step_tick,
  input  logic [4*N_PLAYERS-1:0] dir_req,
  input  logic [8*N_PLAYERS-1:0] start_x,
  input  logic [7*N_PLAYERS-1:0] start_y,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot,
  output logic [N_PLAYERS-1:0]   alive,
  output logic                   round_over
);
  localparam int CW = (N_PLAYERS > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, RUN, PLOT, OVER} state_t;
  state_t state_q, state_d;

  logic [N_PLAYERS-1:0][7:0] pos_x, nx;
  logic [N_PLAYERS-1:0][6:0] pos_y, ny;
  logic [N_PLAYERS-1:0][1:0] dir, ndir;
  logic [N_PLAYERS-1:0]      edge_die, live_mv, hit, new_alive;
  logic [N_PLAYERS-1:0][3:0] req;
  logic [CW-1:0]             cnt;
  logic [7:0]                sel_x;
  logic [6:0]                sel_y;
  logic [2:0]                sel_c;
  logic                      sel_live;

  assign req = dir_req;

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_lane
    tron_lane #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .WRAP(WRAP)) u_lane (
      .x(pos_x[g]), .y(pos_y[g]), .dir(dir[g]), .req(req[g]),
      .nx(nx[g]), .ny(ny[g]), .ndir(ndir[g]), .edge_die(edge_die[g])
    );
  end

  // Head-on check: surviving movers landing on the same cell all die.
  always_comb begin
    live_mv = alive & ~edge_die;
    hit     = '0;
    for (int i = 0; i < N_PLAYERS; i++)
      for (int j = 0; j < N_PLAYERS; j++)
        if (i != j && live_mv[i] && live_mv[j] && nx[i] == nx[j] && ny[i] == ny[j])
          hit[i] = 1'b1;
    new_alive = live_mv & ~hit;
  end

  // Select the player whose plot slot is current.
  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_c    = '0;
    sel_live = 1'b0;
    for (int i = 0; i < N_PLAYERS; i++)
      if (CW'(i) == cnt) begin
        sel_x    = pos_x[i];
        sel_y    = pos_y[i];
        sel_c    = COLOURS[3*i +: 3];
        sel_live = alive[i];
      end
  end

  // Next-state logic; go only matters in IDLE/OVER, step_tick only in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, OVER: if (go) state_d = PLOT;
      RUN:        if (step_tick) state_d = PLOT;
      default:    if (cnt == CW'(N_PLAYERS - 1))
                    state_d = ($countones(alive) <= 1) ? OVER : RUN;
    endcase
  end

  assign round_over = (state_q == OVER);

  // State, player registers and registered plot outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q    <= IDLE;
      pos_x      <= '0;
      pos_y      <= '0;
      dir        <= '0;
      alive      <= '0;
      cnt        <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vga_plot <= 1'b0;
      if ((state_q == IDLE || state_q == OVER) && go) begin
        pos_x <= start_x;
        pos_y <= start_y;
        dir   <= '0;
        alive <= '1;
        cnt   <= '0;
      end else if (state_q == RUN && step_tick) begin
        for (int i = 0; i < N_PLAYERS; i++)
          if (alive[i]) begin
            dir[i] <= ndir[i];
            if (!edge_die[i]) begin
              pos_x[i] <= nx[i];
              pos_y[i] <= ny[i];
            end
          end
        alive <= new_alive;
        cnt   <= '0;
      end else if (state_q == PLOT) begin
        vga_x      <= sel_x;
        vga_y      <= sel_y;
        vga_colour <= sel_c;
        vga_plot   <= sel_live;
        cnt        <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_tron_player_engine.sv
// Directed bench: two engines (no-wrap and wrap) share stimulus; plot
// slots are captured after each go/tick and compared to hand values.
module tb_tron_player_engine;
  logic        CLOCK_50 = 1'b0;
  logic        resetn, go, step_tick;
  logic [7:0]  dir_req;
  logic [15:0] start_x;
  logic [13:0] start_y;
  logic [7:0]  vx0, vx1;
  logic [6:0]  vy0, vy1;
  logic [2:0]  vc0, vc1;
  logic        vp0, vp1, ro0, ro1;
  logic [1:0]  al0, al1;

  int checks = 0;
  int errors = 0;

  // captured plot slots: [dut][slot]
  logic       cp [2][2];
  logic [7:0] cx [2][2];
  logic [6:0] cy [2][2];
  logic [2:0] cc [2][2];
  logic       cr [2][2];

  always #5 CLOCK_50 = ~CLOCK_50;

  tron_player_engine #(.N_PLAYERS(2), .WRAP(0)) dut0 (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .go(go), .step_tick(step_tick),
    .dir_req(dir_req), .start_x(start_x), .start_y(start_y),
    .vga_x(vx0), .vga_y(vy0), .vga_colour(vc0), .vga_plot(vp0),
    .alive(al0), .round_over(ro0));

  tron_player_engine #(.N_PLAYERS(2), .WRAP(1)) dut1 (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .go(go), .step_tick(step_tick),
    .dir_req(dir_req), .start_x(start_x), .start_y(start_y),
    .vga_x(vx1), .vga_y(vy1), .vga_colour(vc1), .vga_plot(vp1),
    .alive(al1), .round_over(ro1));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1 resetn = 1'b1;
  endtask

  task automatic do_go(input int x0, input int y0, input int x1, input int y1);
    start_x = {8'(x1), 8'(x0)};
    start_y = {7'(y1), 7'(y0)};
    go = 1'b1;
    @(posedge CLOCK_50);
    #1 go = 1'b0;
  endtask

  task automatic do_tick(input logic [7:0] req);
    dir_req = req;
    step_tick = 1'b1;
    @(posedge CLOCK_50);
    #1 step_tick = 1'b0;
    dir_req = '0;
  endtask

  // Capture both plot slots of both engines.
  task automatic plot_seq();
    for (int i = 0; i < 2; i++) begin
      @(posedge CLOCK_50);
      #1;
      cp[0][i] = vp0; cx[0][i] = vx0; cy[0][i] = vy0; cc[0][i] = vc0; cr[0][i] = ro0;
      cp[1][i] = vp1; cx[1][i] = vx1; cy[1][i] = vy1; cc[1][i] = vc1; cr[1][i] = ro1;
    end
  endtask

  task automatic chk_slot(input string tag, input int d, input int s,
                          input int p, input int x, input int y, input int c);
    chk({tag, ".plot"}, cp[d][s], p);
    if (p != 0) begin
      chk({tag, ".x"}, cx[d][s], x);
      chk({tag, ".y"}, cy[d][s], y);
      chk({tag, ".col"}, cc[d][s], c);
    end
  endtask

  initial begin
    go = 1'b0; step_tick = 1'b0; dir_req = '0; start_x = '0; start_y = '0;
    do_reset();
    chk("rst.plot", vp0, 0);
    chk("rst.x", vx0, 0);
    chk("rst.y", vy0, 0);
    chk("rst.col", vc0, 0);
    chk("rst.alive", al0, 0);
    chk("rst.over", ro0, 0);

    // initial heads drawn without moving
    do_go(25, 25, 100, 100);
    plot_seq();
    chk_slot("init.p0", 0, 0, 1, 25, 25, 1);
    chk_slot("init.p1", 0, 1, 1, 100, 100, 4);
    chk("init.alive", al0, 3);
    @(posedge CLOCK_50); #1;
    chk("init.plot_end", vp0, 0);

    // P0 turns right; P1 keeps moving down
    do_tick(8'h01);
    plot_seq();
    chk_slot("right.p0", 0, 0, 1, 26, 25, 1);
    chk_slot("right.p1", 0, 1, 1, 100, 101, 4);

    // P0 turns up; a step_tick during PLOT must be dropped
    dir_req = 8'h04; step_tick = 1'b1;
    @(posedge CLOCK_50);
    #1 dir_req = 8'h00;
    @(posedge CLOCK_50);
    #1 step_tick = 1'b0;
    for (int i = 0; i < 1; i++) begin
      @(posedge CLOCK_50); #1;
    end
    chk("up.p1_after_drop", vy0, 102);
    do_tick(8'h00);
    plot_seq();
    chk_slot("drop.p0", 0, 0, 1, 26, 23, 1);
    chk_slot("drop.p1", 0, 1, 1, 100, 103, 4);

    // right, then reverse (left) ignored, then two-bit request ignored
    do_tick(8'h01);
    plot_seq();
    chk_slot("turn.p0", 0, 0, 1, 27, 23, 1);
    do_tick(8'h08);
    plot_seq();
    chk_slot("rev.p0", 0, 0, 1, 28, 23, 1);
    do_tick(8'h06);
    plot_seq();
    chk_slot("multi.p0", 0, 0, 1, 29, 23, 1);

    // edge: P0 at x=159 moves right; dies without wrap, wraps with it
    do_reset();
    do_go(159, 10, 50, 50);
    plot_seq();
    do_tick(8'h01);
    plot_seq();
    chk("edge.alive0", al0, 2);
    chk_slot("edge.p0", 0, 0, 0, 0, 0, 0);
    chk_slot("edge.p1", 0, 1, 1, 50, 51, 4);
    chk("edge.over_slot0", cr[0][0], 0);
    chk("edge.over_after", cr[0][1], 1);
    chk("wrap.alive", al1, 3);
    chk_slot("wrap.p0", 1, 0, 1, 0, 10, 1);
    chk("wrap.over", cr[1][1], 0);

    // step_tick in OVER is dropped
    do_tick(8'h01);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLOCK_50); #1;
      chk("over.noplot", vp0, 0);
    end
    chk("over.alive", al0, 2);
    chk("over.held", ro0, 1);

    // go from OVER restarts the round
    do_go(10, 10, 12, 10);
    chk("restart.over", ro0, 0);
    plot_seq();
    chk("restart.alive", al0, 3);
    chk_slot("restart.p0", 0, 0, 1, 10, 10, 1);
    chk_slot("restart.p1", 0, 1, 1, 12, 10, 4);

    // head-on: both land on (11,10)
    do_tick(8'h81);
    plot_seq();
    chk("headon.alive", al0, 0);
    chk("headon.plot0", cp[0][0], 0);
    chk("headon.plot1", cp[0][1], 0);
    chk("headon.over", cr[0][1], 1);

    // reset in the middle of a plot sequence kills the strobes
    do_reset();
    do_go(30, 30, 60, 60);
    resetn = 1'b0;
    @(posedge CLOCK_50); #1;
    chk("midrst.plot", vp0, 0);
    chk("midrst.alive", al0, 0);
    resetn = 1'b1;
    @(posedge CLOCK_50); #1;
    chk("midrst.plot_after", vp0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
